// File: rtl/moldudp64_pkg.sv
// Shared constants, state encoding and push-request type for the MoldUDP64 transmit path.
package moldudp64_pkg;

   localparam int LEN   = 8;   // bytes per stream beat
   localparam int ML_W  = 16;  // message length / count width
   localparam int SID_W = 80;
   localparam int SEQ_W = 64;
   localparam int MH_W  = 20;  // header bytes: sid + seq + count

   localparam logic [ML_W-1:0] HEARTBEAT_CNT = 16'h0000;
   localparam logic [ML_W-1:0] EOS_CNT       = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_MSG_LEN,
      ST_MSG_DATA,
      ST_FLUSH
   } tx_state_e;

   typedef struct packed {
      logic           vld;
      logic [3:0]     cnt;
      logic [LEN*8-1:0] data;
   } push_t;

   function automatic logic [3:0] popcnt8(input logic [7:0] m);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 8; i++) c = c + 4'(m[i]);
      return c;
   endfunction

endpackage

// File: rtl/moldudp64_tx_packer.sv
// 16-byte shift accumulator: appends 0..8 bytes per cycle, emits 8-byte beats,
// and drains a partial final beat when flushing.
module moldudp64_tx_packer
   import moldudp64_pkg::*;
#(
   parameter int AXI_DATA_W = 64,
   parameter int AXI_KEEP_W = AXI_DATA_W/8
) (
   input  logic                  i_clk,
   input  logic                  i_nreset,
   input  push_t                 i_push,
   input  logic                  i_flush,
   input  logic                  i_tready,
   output logic                  o_tvalid,
   output logic                  o_tlast,
   output logic [AXI_DATA_W-1:0] o_tdata,
   output logic [AXI_KEEP_W-1:0] o_tkeep,
   output logic [4:0]            o_acc_cnt,
   output logic [4:0]            o_cnt_base
);

   logic [2*LEN-1:0][7:0] r_buf;
   logic [4:0]            r_cnt;
   logic [2*LEN-1:0][7:0] w_base;
   logic [2*LEN-1:0][7:0] w_next;
   logic [4:0]            w_cnt_base;
   logic [4:0]            w_cnt_next;
   logic [4:0]            w_off;
   logic                  w_pop;

   assign o_tvalid  = (r_cnt >= 5'(LEN)) || (i_flush && (r_cnt != 5'd0));
   assign o_tlast   = i_flush && (r_cnt != 5'd0) && (r_cnt <= 5'(LEN));
   assign o_tdata   = r_buf[LEN-1:0];
   assign o_acc_cnt = r_cnt;
   assign o_cnt_base = w_cnt_base;
   assign w_pop     = o_tvalid && i_tready;

   always_comb begin
      for (int i = 0; i < AXI_KEEP_W; i++) o_tkeep[i] = o_tvalid && (5'(i) < r_cnt);
   end

   // Bytes at and above r_cnt are always zero, so the shift fills cleanly.
   always_comb begin
      w_base     = r_buf;
      w_cnt_base = r_cnt;
      w_off      = '0;
      if (w_pop) begin
         w_base     = r_buf >> (LEN*8);
         w_cnt_base = (r_cnt >= 5'(LEN)) ? r_cnt - 5'(LEN) : 5'd0;
      end
      w_next = w_base;
      for (int i = 0; i < 2*LEN; i++) begin
         w_off = 5'(i) - w_cnt_base;
         if (i_push.vld && (5'(i) >= w_cnt_base) && (w_off < {1'b0, i_push.cnt}))
            w_next[i] = i_push.data[{w_off[2:0], 3'b000} +: 8];
      end
      w_cnt_next = w_cnt_base + (i_push.vld ? {1'b0, i_push.cnt} : 5'd0);
   end

   always_ff @(posedge i_clk or negedge i_nreset) begin
      if (!i_nreset) begin
         r_buf <= '0;
         r_cnt <= '0;
      end else begin
         r_buf <= w_next;
         r_cnt <= w_cnt_next;
      end
   end

endmodule

// File: rtl/moldudp64_tx.sv
// MoldUDP64 packet encoder: header + length-prefixed messages onto a byte-packed
// 64-bit AXI-Stream, with a running sequence number.
module moldudp64_tx
   import moldudp64_pkg::*;
#(
   parameter int               AXI_DATA_W = 64,
   parameter int               AXI_KEEP_W = AXI_DATA_W/8,
   parameter logic [SEQ_W-1:0] SEQ_INIT   = 64'd1
) (
   input  logic                  clk,
   input  logic                  nreset,
   input  logic                  pkt_v_i,
   output logic                  pkt_ready_o,
   input  logic [ML_W-1:0]       pkt_cnt_i,
   input  logic [SID_W-1:0]      pkt_sid_i,
   input  logic                  mold_msg_v_i,
   output logic                  mold_msg_ready_o,
   input  logic                  mold_msg_start_i,
   input  logic [ML_W-1:0]       mold_msg_len_i,
   input  logic [AXI_KEEP_W-1:0] mold_msg_mask_i,
   input  logic [AXI_DATA_W-1:0] mold_msg_data_i,
   output logic                  udp_axis_tvalid_o,
   input  logic                  udp_axis_tready_i,
   output logic [AXI_DATA_W-1:0] udp_axis_tdata_o,
   output logic [AXI_KEEP_W-1:0] udp_axis_tkeep_o,
   output logic                  udp_axis_tlast_o,
   output logic                  udp_axis_tuser_o,
   output logic [SEQ_W-1:0]      seq_o
);

   tx_state_e          r_state, w_nxt;
   logic [MH_W*8-1:0]  r_hdr;
   logic [ML_W-1:0]    r_cnt;
   logic [SEQ_W-1:0]   r_seq;
   logic [1:0]         r_hph;
   logic [ML_W-1:0]    r_msgs;
   logic [ML_W-1:0]    r_rem;
   logic               r_first;
   logic               r_err;
   logic               r_live;

   push_t              w_push;
   logic [4:0]         w_acc_cnt;
   logic [4:0]         w_cnt_base;
   logic               w_pop;
   logic               w_pkt_acc;
   logic               w_beat;
   logic [3:0]         w_pc;
   logic               w_over;
   logic [ML_W-1:0]    w_rem_nxt;

   assign w_pop     = udp_axis_tvalid_o && udp_axis_tready_i;
   assign w_pc      = popcnt8(mold_msg_mask_i);
   assign w_over    = {12'b0, w_pc} > r_rem;
   assign w_rem_nxt = w_over ? '0 : r_rem - {12'b0, w_pc};
   assign seq_o     = r_seq;
   assign udp_axis_tuser_o = udp_axis_tlast_o && r_err;

   always_comb begin
      w_nxt            = r_state;
      w_push           = '0;
      pkt_ready_o      = 1'b0;
      mold_msg_ready_o = 1'b0;
      w_pkt_acc        = 1'b0;
      w_beat           = 1'b0;
      case (r_state)
         ST_IDLE: begin
            pkt_ready_o = r_live;
            w_pkt_acc   = pkt_v_i && r_live;
            if (w_pkt_acc) w_nxt = ST_HDR;
         end
         ST_HDR: begin
            w_push.cnt = (r_hph == 2'd2) ? 4'd4 : 4'd8;
            for (int i = 0; i < LEN; i++) w_push.data[i*8 +: 8] = r_hdr[MH_W*8-1-8*i -: 8];
            w_push.vld = (w_cnt_base + {1'b0, w_push.cnt}) <= 5'd15;
            if (w_push.vld && (r_hph == 2'd2))
               w_nxt = (r_cnt == HEARTBEAT_CNT || r_cnt == EOS_CNT) ? ST_FLUSH : ST_MSG_LEN;
         end
         ST_MSG_LEN: begin
            // Length prefix only; the start beat itself is consumed in MSG_DATA.
            w_push.cnt        = 4'd2;
            w_push.data[7:0]  = mold_msg_len_i[15:8];
            w_push.data[15:8] = mold_msg_len_i[7:0];
            w_push.vld = mold_msg_v_i && mold_msg_start_i && (w_cnt_base <= 5'd13);
            if (w_push.vld) w_nxt = ST_MSG_DATA;
         end
         ST_MSG_DATA: begin
            mold_msg_ready_o = (w_acc_cnt < 5'd8) || w_pop;
            w_beat      = mold_msg_v_i && mold_msg_ready_o;
            w_push.vld  = w_beat;
            w_push.cnt  = w_pc;
            w_push.data = mold_msg_data_i;
            if (w_beat && (w_rem_nxt == '0))
               w_nxt = (r_msgs == 16'd1) ? ST_FLUSH : ST_MSG_LEN;
         end
         ST_FLUSH: begin
            if (w_pop && udp_axis_tlast_o) w_nxt = ST_IDLE;
         end
         default: w_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state <= ST_IDLE;
         r_seq   <= SEQ_INIT;
         r_hdr   <= '0;
         r_cnt   <= '0;
         r_hph   <= '0;
         r_msgs  <= '0;
         r_rem   <= '0;
         r_first <= 1'b0;
         r_err   <= 1'b0;
         r_live  <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_live  <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               r_err <= 1'b0;
               if (w_pkt_acc) begin
                  r_hdr  <= {pkt_sid_i, r_seq, pkt_cnt_i};
                  r_cnt  <= pkt_cnt_i;
                  r_msgs <= pkt_cnt_i;
                  r_hph  <= '0;
               end
            end
            ST_HDR: begin
               if (w_push.vld) begin
                  r_hdr <= r_hdr << (LEN*8);
                  r_hph <= r_hph + 2'd1;
               end
            end
            ST_MSG_LEN: begin
               if (w_push.vld) begin
                  r_rem   <= mold_msg_len_i;
                  r_first <= 1'b1;
                  if (mold_msg_len_i == '0) r_err <= 1'b1;
               end
            end
            ST_MSG_DATA: begin
               if (w_beat) begin
                  r_first <= 1'b0;
                  r_rem   <= w_rem_nxt;
                  if ((mold_msg_start_i && !r_first) || w_over) r_err <= 1'b1;
                  if (w_rem_nxt == '0) r_msgs <= r_msgs - 16'd1;
               end
            end
            ST_FLUSH: begin
               if (w_pop && udp_axis_tlast_o && r_cnt != HEARTBEAT_CNT && r_cnt != EOS_CNT)
                  r_seq <= r_seq + {48'b0, r_cnt};
            end
            default: ;
         endcase
      end
   end

   moldudp64_tx_packer #(
      .AXI_DATA_W (AXI_DATA_W),
      .AXI_KEEP_W (AXI_KEEP_W)
   ) u_packer (
      .i_clk      (clk),
      .i_nreset   (nreset),
      .i_push     (w_push),
      .i_flush    (r_state == ST_FLUSH),
      .i_tready   (udp_axis_tready_i),
      .o_tvalid   (udp_axis_tvalid_o),
      .o_tlast    (udp_axis_tlast_o),
      .o_tdata    (udp_axis_tdata_o),
      .o_tkeep    (udp_axis_tkeep_o),
      .o_acc_cnt  (w_acc_cnt),
      .o_cnt_base (w_cnt_base)
   );

endmodule

// File: tb/tb_moldudp64_tx.sv
// Directed bench for moldudp64_tx: captures output beats and compares them with
// hand-built wire byte streams.
module tb_moldudp64_tx;

   logic        clk = 1'b0;
   logic        nreset;
   logic        pkt_v_i, pkt_ready_o;
   logic [15:0] pkt_cnt_i;
   logic [79:0] pkt_sid_i;
   logic        mold_msg_v_i, mold_msg_ready_o, mold_msg_start_i;
   logic [15:0] mold_msg_len_i;
   logic [7:0]  mold_msg_mask_i;
   logic [63:0] mold_msg_data_i;
   logic        udp_axis_tvalid_o, udp_axis_tready_i;
   logic [63:0] udp_axis_tdata_o;
   logic [7:0]  udp_axis_tkeep_o;
   logic        udp_axis_tlast_o, udp_axis_tuser_o;
   logic [63:0] seq_o;

   always #5 clk = ~clk;

   moldudp64_tx dut (
      .clk (clk), .nreset (nreset),
      .pkt_v_i (pkt_v_i), .pkt_ready_o (pkt_ready_o),
      .pkt_cnt_i (pkt_cnt_i), .pkt_sid_i (pkt_sid_i),
      .mold_msg_v_i (mold_msg_v_i), .mold_msg_ready_o (mold_msg_ready_o),
      .mold_msg_start_i (mold_msg_start_i), .mold_msg_len_i (mold_msg_len_i),
      .mold_msg_mask_i (mold_msg_mask_i), .mold_msg_data_i (mold_msg_data_i),
      .udp_axis_tvalid_o (udp_axis_tvalid_o), .udp_axis_tready_i (udp_axis_tready_i),
      .udp_axis_tdata_o (udp_axis_tdata_o), .udp_axis_tkeep_o (udp_axis_tkeep_o),
      .udp_axis_tlast_o (udp_axis_tlast_o), .udp_axis_tuser_o (udp_axis_tuser_o),
      .seq_o (seq_o)
   );

   typedef struct {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic        u;
   } beat_t;

   beat_t       cap[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  msg_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          n_last = 0;
   bit          bp = 1'b0;
   bit          prev_stall = 1'b0;
   logic [63:0] prev_d;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Output monitor: capture handshakes, and hold-stability while stalled.
   always @(negedge clk) begin
      if (!nreset) prev_stall = 1'b0;
      else begin
         if (prev_stall) begin
            chk("stall_valid", 64'(udp_axis_tvalid_o), 64'd1);
            chk("stall_data", udp_axis_tdata_o, prev_d);
         end
         if (udp_axis_tvalid_o && udp_axis_tready_i) begin
            cap.push_back('{d: udp_axis_tdata_o, k: udp_axis_tkeep_o,
                            l: udp_axis_tlast_o, u: udp_axis_tuser_o});
            if (udp_axis_tlast_o) n_last++;
         end
         prev_stall = udp_axis_tvalid_o && !udp_axis_tready_i;
         prev_d     = udp_axis_tdata_o;
      end
   end

   initial begin
      udp_axis_tready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         udp_axis_tready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic add_hdr(input logic [79:0] sid, input logic [63:0] seq, input logic [15:0] cnt);
      for (int i = 0; i < 10; i++) exp_q.push_back(sid[79-8*i -: 8]);
      for (int i = 0; i < 8; i++)  exp_q.push_back(seq[63-8*i -: 8]);
      exp_q.push_back(cnt[15:8]);
      exp_q.push_back(cnt[7:0]);
   endtask

   task automatic fill(input int len, input logic [7:0] base);
      msg_q.delete();
      for (int i = 0; i < len; i++) msg_q.push_back(base + 8'(i));
   endtask

   task automatic send_pkt(input logic [79:0] sid, input logic [15:0] cnt);
      bit ok;
      pkt_v_i = 1'b1; pkt_sid_i = sid; pkt_cnt_i = cnt;
      ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
         @(negedge clk);
         ok = pkt_ready_o;
      end
      chk("pkt_accept", 64'(ok), 64'd1);
      @(posedge clk);
      #1;
      pkt_v_i = 1'b0;
   endtask

   // Sends msg_q as one message; err_beat >= 1 re-asserts start on that beat.
   task automatic send_msg(input int err_beat);
      int len;
      int nb;
      bit ok;
      len = msg_q.size();
      nb  = (len + 7) / 8;
      exp_q.push_back(8'(len >> 8));
      exp_q.push_back(8'(len));
      foreach (msg_q[i]) exp_q.push_back(msg_q[i]);
      for (int b = 0; b < nb; b++) begin
         mold_msg_v_i     = 1'b1;
         mold_msg_start_i = (b == 0) || (b == err_beat);
         mold_msg_len_i   = 16'(len);
         mold_msg_mask_i  = '0;
         mold_msg_data_i  = '0;
         for (int i = 0; i < 8; i++)
            if (b*8 + i < len) begin
               mold_msg_mask_i[i]        = 1'b1;
               mold_msg_data_i[i*8 +: 8] = msg_q[b*8 + i];
            end
         ok = 1'b0;
         for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            ok = mold_msg_ready_o;
         end
         chk("msg_accept", 64'(ok), 64'd1);
         @(posedge clk);
         #1;
      end
      mold_msg_v_i = 1'b0;
      mold_msg_start_i = 1'b0;
   endtask

   task automatic wait_last();
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 500 && !ok; c++) begin
         @(posedge clk);
         #1;
         ok = (n_last > 0);
      end
      chk("tlast_seen", 64'(ok), 64'd1);
   endtask

   task automatic check_pkt(input logic exp_u);
      int nb;
      nb = (exp_q.size() + 7) / 8;
      chk("n_beats", 64'(cap.size()), 64'(nb));
      for (int k = 0; k < nb && k < cap.size(); k++) begin
         int          rem;
         logic [7:0]  ek;
         logic [63:0] ed, dm;
         rem = exp_q.size() - 8*k;
         ek = '0; ed = '0; dm = '0;
         for (int i = 0; i < 8; i++)
            if (i < rem) begin
               ek[i] = 1'b1;
               dm[i*8 +: 8] = 8'hFF;
               ed[i*8 +: 8] = exp_q[8*k + i];
            end
         chk("tkeep", 64'(cap[k].k), 64'(ek));
         chk("tdata", cap[k].d & dm, ed);
         chk("tlast", 64'(cap[k].l), 64'(k == nb - 1));
         if (k == nb - 1) chk("tuser", 64'(cap[k].u), 64'(exp_u));
      end
      cap.delete();
      exp_q.delete();
      n_last = 0;
   endtask

   initial begin
      nreset = 1'b0;
      pkt_v_i = 1'b0; pkt_cnt_i = '0; pkt_sid_i = '0;
      mold_msg_v_i = 1'b0; mold_msg_start_i = 1'b0; mold_msg_len_i = '0;
      mold_msg_mask_i = '0; mold_msg_data_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tvalid", 64'(udp_axis_tvalid_o), 64'd0);
      chk("rst_tlast", 64'(udp_axis_tlast_o), 64'd0);
      chk("rst_tuser", 64'(udp_axis_tuser_o), 64'd0);
      chk("rst_tkeep", 64'(udp_axis_tkeep_o), 64'd0);
      chk("rst_msg_rdy", 64'(mold_msg_ready_o), 64'd0);
      chk("rst_pkt_rdy", 64'(pkt_ready_o), 64'd0);
      chk("rst_seq", seq_o, 64'd1);
      @(posedge clk);
      #1;
      nreset = 1'b1;

      // Heartbeat
      send_pkt(80'hDEADBEEF, 16'h0000);
      chk("lat_before", 64'(udp_axis_tvalid_o), 64'd0);
      @(posedge clk);
      #1;
      chk("lat_first", 64'(udp_axis_tvalid_o), 64'd1);
      add_hdr(80'hDEADBEEF, 64'd1, 16'h0000);
      wait_last();
      if (cap.size() == 3) begin
         chk("hb_b0", cap[0].d, 64'hADDE_0000_0000_0000);
         chk("hb_b2", cap[2].d, 64'h0000_0000_0000_0100);
         chk("hb_keep", 64'(cap[2].k), 64'h0F);
      end
      check_pkt(1'b0);
      chk("hb_seq", seq_o, 64'd1);

      // One message DE AD BE EF
      send_pkt(80'hDEADBEEF, 16'd1);
      add_hdr(80'hDEADBEEF, 64'd1, 16'd1);
      msg_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      send_msg(-1);
      wait_last();
      if (cap.size() == 4) begin
         chk("m1_b2", cap[2].d, 64'hADDE_0400_0100_0100);
         chk("m1_b3", cap[3].d, 64'h0000_0000_0000_EFBE);
         chk("m1_keep", 64'(cap[3].k), 64'h03);
      end
      check_pkt(1'b0);
      chk("m1_seq", seq_o, 64'd2);

      // Two messages, no backpressure
      send_pkt(80'h0123_4567_89AB_CDEF_0011, 16'd2);
      add_hdr(80'h0123_4567_89AB_CDEF_0011, 64'd2, 16'd2);
      fill(10, 8'h20); send_msg(-1);
      fill(3, 8'h40);  send_msg(-1);
      wait_last();
      check_pkt(1'b0);
      chk("m2_seq", seq_o, 64'd4);

      // Same two messages under random backpressure
      bp = 1'b1;
      send_pkt(80'h0123_4567_89AB_CDEF_0011, 16'd2);
      add_hdr(80'h0123_4567_89AB_CDEF_0011, 64'd4, 16'd2);
      fill(10, 8'h20); send_msg(-1);
      fill(3, 8'h40);  send_msg(-1);
      wait_last();
      check_pkt(1'b0);
      chk("bp_seq", seq_o, 64'd6);
      bp = 1'b0;
      @(posedge clk);
      #1;

      // End of session
      send_pkt(80'hDEADBEEF, 16'hFFFF);
      add_hdr(80'hDEADBEEF, 64'd6, 16'hFFFF);
      wait_last();
      if (cap.size() == 3) chk("eos_b2", cap[2].d, 64'h0000_0000_FFFF_0600);
      check_pkt(1'b0);
      chk("eos_seq", seq_o, 64'd6);

      // Start re-asserted mid-message
      send_pkt(80'hDEADBEEF, 16'd1);
      add_hdr(80'hDEADBEEF, 64'd6, 16'd1);
      fill(10, 8'h60); send_msg(1);
      wait_last();
      check_pkt(1'b1);
      chk("err_seq", seq_o, 64'd7);

      // Reset mid-packet
      send_pkt(80'hDEADBEEF, 16'd1);
      mold_msg_v_i = 1'b1; mold_msg_start_i = 1'b1; mold_msg_len_i = 16'd10;
      mold_msg_mask_i = 8'hFF; mold_msg_data_i = 64'h0807_0605_0403_0201;
      repeat (5) @(posedge clk);
      #1;
      nreset = 1'b0;
      mold_msg_v_i = 1'b0; mold_msg_start_i = 1'b0;
      @(negedge clk);
      chk("mr_tvalid", 64'(udp_axis_tvalid_o), 64'd0);
      chk("mr_tlast", 64'(udp_axis_tlast_o), 64'd0);
      chk("mr_tuser", 64'(udp_axis_tuser_o), 64'd0);
      chk("mr_tkeep", 64'(udp_axis_tkeep_o), 64'd0);
      chk("mr_tdata", udp_axis_tdata_o, 64'd0);
      chk("mr_msg_rdy", 64'(mold_msg_ready_o), 64'd0);
      chk("mr_pkt_rdy", 64'(pkt_ready_o), 64'd0);
      chk("mr_seq", seq_o, 64'd1);
      chk("mr_no_last", 64'(n_last), 64'd0);
      @(posedge clk);
      #1;
      nreset = 1'b1;
      cap.delete();
      exp_q.delete();
      n_last = 0;
      send_pkt(80'hDEADBEEF, 16'd1);
      add_hdr(80'hDEADBEEF, 64'd1, 16'd1);
      msg_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      send_msg(-1);
      wait_last();
      check_pkt(1'b0);
      chk("post_rst_seq", seq_o, 64'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
